fir_interp2: RTL and testbench

FIR_INTERP2 -- requirements
Module: fir_interp2

---
 rtl/fir_interp_pkg.sv | 41 ++++
 rtl/fir_serial_mac.sv | 44 ++++
 rtl/fir_interp2.sv | 143 ++++++++++++++
 tb/tb_fir_interp2.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_interp_pkg.sv
// Shared definitions for the 2x polyphase FIR interpolator.
//   - default sample width, output shift, coefficient width, accumulator width
//   - default prototype coefficients C0..C7
//   - FSM state type
//   - sat_clamp(): clamp a wide signed value into a w-bit signed range
package fir_interp_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned SHIFT_DEF = 8;
  localparam int unsigned CW        = 16;
  localparam int unsigned ACC_W_DEF = 2 * DW_DEF + 2;

  localparam logic signed [CW-1:0] C0_DEF = 16'sd50;
  localparam logic signed [CW-1:0] C1_DEF = 16'sd100;
  localparam logic signed [CW-1:0] C2_DEF = 16'sd150;
  localparam logic signed [CW-1:0] C3_DEF = 16'sd200;
  localparam logic signed [CW-1:0] C4_DEF = 16'sd200;
  localparam logic signed [CW-1:0] C5_DEF = 16'sd150;
  localparam logic signed [CW-1:0] C6_DEF = 16'sd100;
  localparam logic signed [CW-1:0] C7_DEF = 16'sd50;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    OUT0,
    MAC1,
    OUT1
  } fir_state_e;

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned     w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/fir_serial_mac.sv
// Serial multiply-accumulate engine: one a*b product added per enabled cycle.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   clear      : zero accumulator and tap counter (wins over en)
//   en         : accumulate a*b this cycle and advance the tap counter
//   a, b       : signed sample / signed coefficient operands
//   acc        : running sum, AW bits wide
//   tap        : 2-bit index of the tap being processed next
module fir_serial_mac
  import fir_interp_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [AW-1:0] acc,
  output logic [1:0]           tap
);

  localparam int unsigned PW = DW + CW;

  logic signed [PW-1:0] prod;

  // Operands are sign-extended to full product width before multiplying.
  assign prod = PW'(a) * PW'(b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      tap <= '0;
    end else if (clear) begin
      acc <= '0;
      tap <= '0;
    end else if (en) begin
      acc <= acc + AW'(prod);
      tap <= tap + 2'd1;
    end
  end

endmodule

// File: rtl/fir_interp2.sv
// 2x polyphase FIR interpolator. Each accepted input sample yields two output
// samples (phase 0 from even coefficients, phase 1 from odd coefficients),
// each computed by a 4-cycle serial MAC over a 4-entry delay line.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready only in IDLE
//   in_data             : signed base-rate sample
//   out_valid/out_ready : output handshake; out_valid only in OUT0/OUT1
//   out_data            : signed 2x-rate sample, stable while stalled
// Build option: define FIR_INTERP_SAT_EN to clamp the shifted result into the
// DW-bit range; otherwise the low DW bits are output (two's-complement wrap).
module fir_interp2
  import fir_interp_pkg::*;
#(
  parameter int unsigned          DW    = DW_DEF,
  parameter int unsigned          SHIFT = SHIFT_DEF,
  parameter logic signed [CW-1:0] C0    = C0_DEF,
  parameter logic signed [CW-1:0] C1    = C1_DEF,
  parameter logic signed [CW-1:0] C2    = C2_DEF,
  parameter logic signed [CW-1:0] C3    = C3_DEF,
  parameter logic signed [CW-1:0] C4    = C4_DEF,
  parameter logic signed [CW-1:0] C5    = C5_DEF,
  parameter logic signed [CW-1:0] C6    = C6_DEF,
  parameter logic signed [CW-1:0] C7    = C7_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data
);

  localparam int unsigned AW = DW + CW + 2;
  localparam logic signed [CW-1:0] COEF [8] = '{C0, C1, C2, C3, C4, C5, C6, C7};

  fir_state_e state, state_nxt;

  logic signed [DW-1:0] dly [4];
  logic                 accept;
  logic                 out_hs;
  logic                 mac_clr;
  logic                 mac_en;
  logic                 phase;
  logic [1:0]           tap;
  logic signed [DW-1:0] mac_a;
  logic signed [CW-1:0] mac_b;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] shifted;

  // in_ready is gated by reset so it reads 0 for the whole reset pulse.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == OUT0) || (state == OUT1);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign phase     = (state == MAC1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = MAC0;
          mac_clr   = 1'b1;
        end
      end
      MAC0: begin
        mac_en = 1'b1;
        if (tap == 2'd3) state_nxt = OUT0;
      end
      OUT0: begin
        if (out_hs) begin
          state_nxt = MAC1;
          mac_clr   = 1'b1;
        end
      end
      MAC1: begin
        mac_en = 1'b1;
        if (tap == 2'd3) state_nxt = OUT1;
      end
      OUT1: begin
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) dly[i] <= '0;
    end else if (accept) begin
      dly[0] <= in_data;
      dly[1] <= dly[0];
      dly[2] <= dly[1];
      dly[3] <= dly[2];
    end
  end

  // Tap k of phase p uses delay entry k and coefficient C[2k+p].
  always_comb begin
    mac_a = dly[tap];
    mac_b = COEF[{tap, phase}];
  end

  fir_serial_mac #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clr),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (acc),
    .tap   (tap)
  );

  // The accumulator is frozen outside MAC states, so driving out_data straight
  // from it keeps the value stable under backpressure without an extra register.
  assign shifted = acc >>> SHIFT;

`ifdef FIR_INTERP_SAT_EN
  logic signed [63:0] clamped;
  logic               sat_unused_hi;
  always_comb clamped = sat_clamp(64'(shifted), DW);
  assign out_data      = clamped[DW-1:0];
  assign sat_unused_hi = ^clamped[63:DW];
`else
  logic wrap_unused_hi;
  assign out_data       = shifted[DW-1:0];
  assign wrap_unused_hi = ^shifted[AW-1:DW];
`endif

endmodule

// File: tb/tb_fir_interp2.sv
module tb_fir_interp2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  longint hist [4];
  longint coef_m [8] = '{50, 100, 150, 200, 200, 150, 100, 50};
  longint imp_tab [8] = '{50, 100, 150, 200, 200, 150, 100, 50};

  fir_interp2 #(
    .DW    (16),
    .SHIFT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference: direct convolution of the last four accepted samples with
  // the even (phase 0) or odd (phase 1) coefficients, then shift and limit.
  function automatic longint model_out(input int ph);
    longint s = 0;
    for (int k = 0; k < 4; k++) s += hist[k] * coef_m[2*k + ph];
    s = s >>> 8;
`ifdef FIR_INTERP_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    s = s & 64'hFFFF;
    if (s >= 32768) s -= 65536;
`endif
    return s;
  endfunction

  task automatic model_push(input longint x);
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) hist[k] = 0;
  endtask

  // Wait (bounded) for out_valid; returns edges counted since the last edge.
  task automatic wait_out(input bit noise, output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      out_ready = 1'($urandom);
      if (noise) begin
        in_valid = 1'($urandom);
        in_data  = 16'($urandom);
      end
      @(posedge clk);
      n++;
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_sample(input longint x, input int stall, input bit noise,
                            output longint y0, output longint y1);
    int     n;
    longint held;
    check("in_ready_idle", longint'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 16'(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_push(x);

    wait_out(noise, n);
    check("lat0_edges", n + 1, 5);
    out_ready = (stall == 0);
    held = longint'(out_data);
    for (int s = 0; s < stall; s++) begin
      if (noise) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", longint'(out_valid), 1);
      check("bp_data", longint'(out_data), held);
      check("bp_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    y0 = longint'(out_data);
    check("phase0", y0, model_out(0));
    @(posedge clk);

    wait_out(noise, n);
    check("lat1_edges", n + 1, 5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y1 = longint'(out_data);
    check("phase1", y1, model_out(1));
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after", longint'(in_ready), 1);
    check("valid_after", longint'(out_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    longint y0, y1;
    int     seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_in_ready", longint'(in_ready), 1);

    // Impulse
    for (int i = 0; i < 10; i++) begin
      run_sample((i == 0) ? 256 : 0, 0, 1'b0, y0, y1);
      check("imp0", y0, (i < 4) ? imp_tab[2*i] : 0);
      check("imp1", y1, (i < 4) ? imp_tab[2*i+1] : 0);
    end

    // Step
    for (int i = 0; i < 6; i++) begin
      run_sample(256, 0, 1'b1, y0, y1);
      if (i >= 3) begin
        check("step0", y0, 500);
        check("step1", y1, 500);
      end
    end

    // Overflow, positive then negative full scale
    for (int i = 0; i < 5; i++) run_sample(32767, 0, 1'b0, y0, y1);
`ifdef FIR_INTERP_SAT_EN
    check("ovf_pos", y0, 32767);
`else
    check("ovf_pos", y0, -1538);
`endif
    for (int i = 0; i < 5; i++) run_sample(-32768, 0, 1'b0, y0, y1);
`ifdef FIR_INTERP_SAT_EN
    check("ovf_neg", y1, -32768);
`else
    check("ovf_neg", y1, 1536);
`endif

    // Backpressure: 10 stalled cycles in OUT0 with competing input traffic
    run_sample(1234, 10, 1'b1, y0, y1);
    run_sample(-777, 10, 1'b1, y0, y1);

    // Mid-computation reset two edges after an accept
    in_valid = 1'b1;
    in_data  = 16'sd9999;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    check("mid_rst_data", longint'(out_data), 0);
    reset = 1'b0;
    model_clear();
    seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_out", seen, 0);
    for (int i = 0; i < 5; i++) begin
      run_sample((i == 0) ? 256 : 0, 0, 1'b0, y0, y1);
      check("rimp0", y0, (i < 4) ? imp_tab[2*i] : 0);
      check("rimp1", y1, (i < 4) ? imp_tab[2*i+1] : 0);
    end

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      longint x;
      x = longint'($signed(16'($urandom)));
      run_sample(x, int'($urandom_range(0, 3)), 1'($urandom), y0, y1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
